// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
//   state_t   : controller state (IDLE, RUN, PAUSE, STEP)
//   LED_*     : one-hot state indicator codes driven on state_led
//   BCD_MAX   : largest legal decade value
//   led_of()  : state -> one-hot LED code
package stopwatch_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_STEP  = 2'd3
   } state_t;

   localparam logic [3:0] LED_IDLE  = 4'b0001;
   localparam logic [3:0] LED_RUN   = 4'b0010;
   localparam logic [3:0] LED_PAUSE = 4'b0100;
   localparam logic [3:0] LED_STEP  = 4'b1000;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic [3:0] led_of(input state_t s);
      case (s)
         S_RUN:   return LED_RUN;
         S_PAUSE: return LED_PAUSE;
         S_STEP:  return LED_STEP;
         default: return LED_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade of the stopwatch counter.
//   clk, rst : clock, asynchronous active-high reset
//   en       : apply one count step to this decade this cycle
//   down     : 0 = increment, 1 = decrement
//   digit    : current decade value, always 0..9
//   cout     : carry (up) or borrow (down) into the next decade, combinational
module bcd_decade
   import stopwatch_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       down,
   output logic [3:0] digit,
   output logic       cout
);

   // Wrap condition is 9 going up and 0 going down; the chain of couts
   // resolves the whole ripple in a single cycle.
   assign cout = en & (down ? (digit == 4'd0) : (digit == BCD_MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit <= 4'd0;
      end else if (en) begin
         if (down) digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
         else      digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
      end
   end

endmodule

// File: rtl/stopwatch_bcd.sv
// Multi-decade BCD stopwatch with run/pause/single-step control and lap hold.
//   clk        : system clock, all state on its rising edge
//   rst        : asynchronous active-high reset
//   start      : start request (async level, edge-detected)
//   stop       : stop request (async level, edge-detected)
//   inc        : single-step request (async level, edge-detected)
//   lap        : lap-freeze toggle (async level, edge-detected)
//   down       : count direction, 0 = up, 1 = down
//   bcd        : displayed value, digit 0 in bits [3:0]
//   state_led  : one-hot state, bit0 IDLE, bit1 RUN, bit2 PAUSE, bit3 STEP
//   lap_active : display frozen on the lap hold register
//   evt        : one-cycle pulse on up rollover or down expiry
module stopwatch_bcd
   import stopwatch_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 50_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic                inc,
   input  logic                lap,
   input  logic                down,
   output logic [4*DIGITS-1:0] bcd,
   output logic [3:0]          state_led,
   output logic                lap_active,
   output logic                evt
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [3:0] req, sync_p0, sync_p1, armed, press;
   logic [1:0] fill;
   logic       press_start, press_stop, press_inc, press_lap;

   state_t              state, state_nxt;
   logic [PW-1:0]       presc;
   logic                tick, count_evt, expire;
   logic [DIGITS:0]     cell_en;
   logic [4*DIGITS-1:0] count, hold;

   assign req = {lap, inc, stop, start};

   // Input synchroniser. A request is only armed once the synchronised level
   // has been seen low; 'fill' keeps the freshly cleared chain from passing
   // for a low level, so an input held high across reset stays silent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         fill    <= '0;
         armed   <= '0;
      end else begin
         sync_p0 <= req;
         sync_p1 <= sync_p0;
         fill    <= {fill[0], 1'b1};
         if (fill[1]) armed <= (armed & ~press) | ~sync_p1;
      end
   end

   assign press       = sync_p1 & armed;
   assign press_start = press[0];
   assign press_stop  = press[1];
   assign press_inc   = press[2];
   assign press_lap   = press[3];

   // Tick prescaler, held at zero outside RUN so every entry to RUN starts a
   // full tick period.
   assign tick = (state == S_RUN) && (presc == PW'(TICK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          presc <= '0;
      else if (state != S_RUN || tick)  presc <= '0;
      else                              presc <= presc + PW'(1);
   end

   assign count_evt = tick | (state == S_STEP);

   // Counting down from zero holds zero and expires instead of wrapping.
   assign expire     = count_evt & down & (count == '0);
   assign cell_en[0] = count_evt & ~expire;

   for (genvar g = 0; g < DIGITS; g++) begin : g_decade
      bcd_decade u_decade (
         .clk   (clk),
         .rst   (rst),
         .en    (cell_en[g]),
         .down  (down),
         .digit (count[4*g +: 4]),
         .cout  (cell_en[g+1])
      );
   end

   // Top-decade carry can only occur counting up, since the all-zero borrow
   // case is masked above; it is exactly the all-9s rollover.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) evt <= 1'b0;
      else     evt <= cell_en[DIGITS] | expire;
   end

   // Stop outranks start, start outranks inc.
   always_comb begin
      state_nxt = state;
      if (expire) begin
         state_nxt = S_PAUSE;
      end else begin
         case (state)
            S_IDLE, S_PAUSE: begin
               if (!press_stop) begin
                  if (press_start)    state_nxt = S_RUN;
                  else if (press_inc) state_nxt = S_STEP;
               end
            end
            S_RUN:   if (press_stop) state_nxt = S_PAUSE;
            S_STEP:  state_nxt = S_PAUSE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // state_led is registered together with state, so it always shows the
   // decode of the state register's current value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         state_led <= LED_IDLE;
      end else begin
         state     <= state_nxt;
         state_led <= led_of(state_nxt);
      end
   end

   // Lap capture samples the count register before any same-cycle update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lap_active <= 1'b0;
         hold       <= '0;
      end else if (press_lap) begin
         lap_active <= ~lap_active;
         if (!lap_active) hold <= count;
      end
   end

   assign bcd = lap_active ? hold : count;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd (DIGITS=2, TICK_DIV=4).
// The reference model keeps the count as an integer and applies each press
// three edges after the bench raises the input; every predicted change of the
// visible outputs is queued and a separate monitor pops one entry per change.
module tb_stopwatch_bcd;

   localparam int DIGITS   = 2;
   localparam int TICK_DIV = 4;
   localparam int MAXV     = 100;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_STEP = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0, stop = 1'b0, inc = 1'b0, lap = 1'b0, down = 1'b0;
   logic [4*DIGITS-1:0] bcd;
   logic [3:0]          state_led;
   logic                lap_active;
   logic                evt;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   int m_st = M_IDLE, m_cnt = 0, m_hold = 0, m_age = 0;
   bit m_lap = 1'b0, m_evt = 1'b0;
   logic [3:0] pend [int];
   bit   [3:0] lvl = '0;

   logic [13:0] exp_q [$];
   logic [13:0] last_push = 'x;
   logic [13:0] seen      = 'x;

   always #5 clk = ~clk;

   stopwatch_bcd #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .inc        (inc),
      .lap        (lap),
      .down       (down),
      .bcd        (bcd),
      .state_led  (state_led),
      .lap_active (lap_active),
      .evt        (evt)
   );

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   function automatic logic [13:0] model_snap();
      int vis;
      vis = m_lap ? m_hold : m_cnt;
      return {to_bcd(vis), 4'(1 << m_st), m_lap, m_evt};
   endfunction

   task automatic push_if_changed();
      logic [13:0] s;
      s = model_snap();
      if (s !== last_push) begin
         exp_q.push_back(s);
         last_push = s;
      end
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_cnt = 0; m_hold = 0; m_age = 0;
      m_lap = 1'b0; m_evt = 1'b0;
      pend.delete();
      push_if_changed();
   endtask

   // One rising clock edge of the reference behaviour.
   task automatic model_edge(input int n);
      logic [3:0] p;
      bit ce, expd;
      int s, ns;
      p = 4'b0;
      if (pend.exists(n)) begin
         p = pend[n];
         pend.delete(n);
      end
      s    = m_st;
      ce   = (s == M_RUN && ((m_age + 1) % TICK_DIV) == 0) || (s == M_STEP);
      expd = 1'b0;
      m_evt = 1'b0;
      if (p[3]) begin
         if (!m_lap) m_hold = m_cnt;
         m_lap = !m_lap;
      end
      if (ce) begin
         if (down) begin
            if (m_cnt == 0) begin expd = 1'b1; m_evt = 1'b1; end
            else m_cnt = m_cnt - 1;
         end else begin
            m_cnt = (m_cnt + 1) % MAXV;
            if (m_cnt == 0) m_evt = 1'b1;
         end
      end
      ns = s;
      case (s)
         M_IDLE, M_PAUSE: if (!p[1]) begin
                             if (p[0])      ns = M_RUN;
                             else if (p[2]) ns = M_STEP;
                          end
         M_RUN:           if (p[1]) ns = M_PAUSE;
         default:         ns = M_PAUSE;
      endcase
      if (expd) ns = M_PAUSE;
      if (ns == M_RUN) m_age = (s == M_RUN) ? m_age + 1 : 0;
      m_st = ns;
      push_if_changed();
   endtask

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst) model_edge(cyc);
   end

   // Monitor: one scoreboard entry per observed change of the outputs.
   always @(negedge clk) begin
      logic [13:0] cur, e;
      cur = {bcd, state_led, lap_active, evt};
      if (cur !== seen) begin
         seen = cur;
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_change at cyc %0d: got bcd=%h led=%b lap=%b evt=%b, none expected",
                     cyc, cur[13:6], cur[5:2], cur[1], cur[0]);
         end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
               fails++;
               $display("FAIL snapshot at cyc %0d: got bcd=%h led=%b lap=%b evt=%b, expected bcd=%h led=%b lap=%b evt=%b",
                        cyc, cur[13:6], cur[5:2], cur[1], cur[0], e[13:6], e[5:2], e[1], e[0]);
            end
         end
      end
   end

   // id: 0 start, 1 stop, 2 inc, 3 lap
   task automatic set_in(input int id, input bit v);
      if (v && !lvl[id] && !rst) begin
         if (!pend.exists(cyc + 3)) pend[cyc + 3] = 4'b0;
         pend[cyc + 3][id] = 1'b1;
      end
      lvl[id] = v;
      case (id)
         0:       start = v;
         1:       stop  = v;
         2:       inc   = v;
         default: lap   = v;
      endcase
   endtask

   task automatic press(input int id, input int hi, input int lo);
      @(posedge clk); #1;
      set_in(id, 1'b1);
      repeat (hi) @(posedge clk);
      #1;
      set_in(id, 1'b0);
      repeat (lo) @(posedge clk);
   endtask

   task automatic press_both();
      @(posedge clk); #1;
      set_in(0, 1'b1);
      set_in(1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      set_in(0, 1'b0);
      set_in(1, 1'b0);
      repeat (4) @(posedge clk);
   endtask

   task automatic do_reset(input int len);
      @(negedge clk); #1;
      rst = 1'b1;
      model_reset();
      repeat (len) @(negedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   initial begin
      int op;
      #1;
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      wait_cyc(3);

      // start, count a few ticks, stop and hold
      press(0, 2, 3); wait_cyc(12);
      press(1, 2, 3); wait_cyc(6);

      // step up to 05, then a long inc hold gives exactly one step
      while (m_cnt < 5) press(2, 1, 4);
      press(2, 10, 4);

      // lap freeze while running, then release
      press(0, 2, 3); wait_cyc(4);
      press(3, 2, 3); wait_cyc(14);
      press(3, 2, 3);
      press(1, 2, 3);

      // start and stop together while running
      press(0, 2, 3); wait_cyc(5);
      press_both();

      // run through the 99 -> 00 rollover
      press(0, 2, 3); wait_cyc(420);
      press(1, 2, 3);

      // count down to zero and expire
      @(posedge clk); #1; down = 1'b1;
      press(0, 2, 3); wait_cyc(460);
      press(1, 2, 3);
      @(posedge clk); #1; down = 1'b0;

      // reset in the middle of a run
      press(0, 2, 3); wait_cyc(9);
      do_reset(2);

      // start held high across reset release gives no press
      @(posedge clk); #1; set_in(0, 1'b1);
      wait_cyc(6);
      do_reset(2);
      wait_cyc(10);
      @(posedge clk); #1; set_in(0, 1'b0);
      wait_cyc(4);
      press(0, 2, 3); wait_cyc(10);
      press(1, 2, 3);

      // randomized mix
      for (int i = 0; i < 70; i++) begin
         op = int'($urandom_range(0, 11));
         case (op)
            0, 1, 2, 3: press(op, int'($urandom_range(1, 10)), int'($urandom_range(3, 6)));
            4:          press(0, 1, 3);
            5:          wait_cyc(int'($urandom_range(1, 30)));
            6:          begin @(posedge clk); #1; down = ~down; end
            7:          press_both();
            8:          if ($urandom_range(0, 3) == 0) do_reset(int'($urandom_range(1, 3)));
            default:    wait_cyc(int'($urandom_range(20, 100)));
         endcase
      end

      wait_cyc(20);
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL leftover_expected: got %0d unobserved changes, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
